// File: rtl/led_fade_pwm_driver.sv
// rtl/led_fade_pwm_driver.sv - per-LED brightness ramp with 256-step PWM output
module led_fade_pwm_driver #(
    parameter int NUM_LEDS   = 2,
    parameter int STEP_DIV   = 50000,
    parameter int STEP_SIZE  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [NUM_LEDS-1:0] at_target
);

    localparam logic [1:0] S_OFF       = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_ON        = 2'd2;
    localparam logic [1:0] S_RAMP_DOWN = 2'd3;

    localparam logic       POL_BIT  = (ACTIVE_LOW != 0);
    localparam logic [8:0] STEP_AMT = 9'(STEP_SIZE);

    logic [23:0]         presc;
    logic                step_tick;
    logic [7:0]          pwm_cnt;
    logic [NUM_LEDS-1:0] led_in_q;

    assign step_tick = (presc == 24'(STEP_DIV - 1));

    // Ramp-rate prescaler: wraps after STEP_DIV clocks, shared by all channels
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (step_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    // Free-running PWM phase counter and target input register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pwm_cnt  <= '0;
            led_in_q <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + 8'd1;
            led_in_q <= led_in;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        logic [7:0] level;
        logic [7:0] level_up;
        logic [7:0] level_dn;
        logic [8:0] sum_up;
        logic [8:0] diff_dn;
        logic [1:0] state;
        logic [1:0] state_next;
        logic       lit;
        logic       led_q;
        logic       at_q;

        // Saturating step arithmetic; bit 8 flags overflow or borrow
        always_comb begin
            sum_up   = {1'b0, level} + STEP_AMT;
            diff_dn  = {1'b0, level} - STEP_AMT;
            level_up = sum_up[8]  ? 8'hFF : sum_up[7:0];
            level_dn = diff_dn[8] ? 8'h00 : diff_dn[7:0];
            lit      = (level == 8'hFF) || (pwm_cnt < level);
        end

        // Channel FSM: direction follows the registered target immediately
        always_comb begin
            state_next = state;
            case (state)
                S_OFF:       if (led_in_q[i]) state_next = S_RAMP_UP;
                S_RAMP_UP:   if (!led_in_q[i]) state_next = S_RAMP_DOWN;
                             else if (level == 8'hFF) state_next = S_ON;
                S_ON:        if (!led_in_q[i]) state_next = S_RAMP_DOWN;
                S_RAMP_DOWN: if (led_in_q[i]) state_next = S_RAMP_UP;
                             else if (level == 8'h00) state_next = S_OFF;
                default:     state_next = S_OFF;
            endcase
        end

        // Level, state and registered pin/status outputs
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                level <= '0;
                state <= S_OFF;
                led_q <= POL_BIT;
                at_q  <= 1'b1;
            end else begin
                if (step_tick) begin
                    level <= led_in_q[i] ? level_up : level_dn;
                end
                state <= state_next;
                led_q <= lit ^ POL_BIT;
                at_q  <= (state_next == S_ON) || (state_next == S_OFF);
            end
        end

        assign led_out[i]   = led_q;
        assign at_target[i] = at_q;
    end

endmodule

// File: tb/tb_led_fade_pwm_driver.sv
// tb/tb_led_fade_pwm_driver.sv - randomized scoreboard bench for led_fade_pwm_driver
module tb_led_fade_pwm_driver;

    localparam int NL  = 2;
    localparam int DIV = 4;
    localparam int SS  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NL-1:0] led_in = '0;
    logic [NL-1:0] led_out;
    logic [NL-1:0] at_target;

    led_fade_pwm_driver #(
        .NUM_LEDS  (NL),
        .STEP_DIV  (DIV),
        .STEP_SIZE (SS),
        .ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .led_in   (led_in),
        .led_out  (led_out),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] lo;
        logic [NL-1:0] at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model state: brightness, registered target and its previous value,
    // and elapsed cycles since reset release (sets both step timing and PWM phase)
    int lvl [NL];
    bit tq  [NL];
    bit tqp [NL];
    int t;

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led_out !== e.lo) begin
                errors++;
                $display("FAIL led_out cyc=%0d got=%b want=%b", cyc_no, led_out, e.lo);
            end
            checks++;
            if (at_target !== e.at) begin
                errors++;
                $display("FAIL at_target cyc=%0d got=%b want=%b", cyc_no, at_target, e.at);
            end
        end
    end

    // Advance the model across one clock edge that saw reset rn and input li
    function automatic exp_t model_step(input logic rn, input logic [NL-1:0] li);
        exp_t e;
        int   nl;
        e = '0;
        if (!rn) begin
            for (int c = 0; c < NL; c++) begin
                lvl[c] = 0;
                tq[c]  = 0;
                tqp[c] = 0;
            end
            t    = 0;
            e.lo = '1;
            e.at = '1;
        end else begin
            for (int c = 0; c < NL; c++) begin
                // settled: level sits at the extreme the target asks for, and the
                // target has not just changed
                e.at[c] = (lvl[c] == (tq[c] ? 255 : 0)) && (tqp[c] == tq[c]);
                // ACTIVE_LOW: pin low while lit
                e.lo[c] = !((lvl[c] == 255) || ((t % 256) < lvl[c]));
                if ((t % DIV) == DIV - 1) begin
                    nl     = tq[c] ? lvl[c] + SS : lvl[c] - SS;
                    lvl[c] = (nl > 255) ? 255 : ((nl < 0) ? 0 : nl);
                end
                tqp[c] = tq[c];
                tq[c]  = li[c];
            end
            t++;
        end
        return e;
    endfunction

    task automatic cycle(input logic rn, input logic [NL-1:0] li);
        reset_n = rn;
        led_in  = li;
        @(posedge clk);
        #1;
        cyc_no++;
        exp_q.push_back(model_step(rn, li));
    endtask

    task automatic hold(input logic [NL-1:0] li, input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, li);
    endtask

    initial begin
        logic [NL-1:0] cur;
        logic [NL-1:0] flip;
        int            mode;

        // Reset held with targets on
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'b11);

        // Directed: ch0 full ramp up to saturation, then fall back partway
        hold(2'b01, 80);
        hold(2'b00, 4 * 12);
        hold(2'b01, 4 * 4 + 1);
        // Freeze ch0 mid-level by toggling target off and on between ticks
        hold(2'b00, 2);
        hold(2'b01, 2);
        hold(2'b00, 256 + 80);
        // Reversal from mid-ramp, then reset mid-ramp on ch1
        hold(2'b01, 33);
        hold(2'b00, 40);
        hold(2'b10, 25);
        cycle(1'b0, 2'b10);
        hold(2'b10, 90);

        // Randomized segments: long holds, short glitches, occasional resets
        cur = 2'b10;
        for (int s = 0; s < 90; s++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                for (int k = 0; k < $urandom_range(1, 3); k++) cycle(1'b0, cur);
            end else if (mode <= 2) begin
                flip = NL'($urandom_range(1, 3));
                hold(cur ^ flip, $urandom_range(1, 3));
                hold(cur, $urandom_range(1, 6));
            end else begin
                cur = NL'($urandom_range(0, 3));
                hold(cur, $urandom_range(1, 120));
            end
        end

        // Drain remaining expectations (bounded)
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm_driver.md
Name: led_fade_pwm_driver

Overview:
- Downstream consumer of the LED PIO `out_port`. Drives the board LED pins.
- Each PIO bit is a per-LED on/off target. The block ramps an 8-bit brightness level toward that target at a programmable rate.
- Brightness is rendered as 256-step PWM on the LED pin.
- Output polarity is selectable to match the active-low LEDs on the Cyclone III starter board.

Parameters:
- NUM_LEDS, 2: number of LED channels; equals the PIO `out_port` width.
- STEP_DIV, 50000: clocks per ramp step. Legal range 1..2^24-1.
- STEP_SIZE, 1: level increment or decrement per ramp step. Legal range 1..255.
- ACTIVE_LOW, 1: 1 means `led_out` is low when the LED is lit.

Ports:
- clk, input, 1: system clock. Single clock domain.
- reset_n, input, 1: reset, synchronous and active-low.
- led_in, input, NUM_LEDS: per-LED target from the PIO `out_port` (1 = on).
- led_out, output, NUM_LEDS: PWM drive to the LED pins. Polarity is set by ACTIVE_LOW.
- at_target, output, NUM_LEDS: 1 when the channel level equals its target extreme (255 or 0).

Behaviour:
- Reset is sampled on a clk rising edge only. While reset_n is 0:
  - all levels are 0;
  - the prescaler, `pwm_cnt` and `led_in_q` are 0;
  - every FSM is in OFF;
  - `led_out` is all 1 if ACTIVE_LOW, else all 0;
  - `at_target` is all 1.
- Reset asserted mid-ramp forces these values at the next edge. No residual state remains.
- Input register: `led_in_q` <= `led_in` every cycle. All decisions use `led_in_q`.
- Prescaler: counts 0..STEP_DIV-1 and wraps to 0. `step_tick` is 1 in the cycle the count equals STEP_DIV-1. With STEP_DIV=1, `step_tick` is 1 every cycle.
- PWM counter: 8-bit `pwm_cnt` increments every cycle and wraps 255->0.
- Per-channel level register (8-bit), updated only on `step_tick`:
  - target 1: level <= min(level+STEP_SIZE, 255). Use 9-bit intermediate arithmetic so there is no wrap.
  - target 0: level <= max(level-STEP_SIZE, 0). No underflow.
- Per-channel FSM states:
  - OFF (level 0, target 0). On target 1 -> RAMP_UP.
  - RAMP_UP. Reaches level 255 with target 1 -> ON. Target 0 -> RAMP_DOWN.
  - ON (level 255, target 1). On target 0 -> RAMP_DOWN.
  - RAMP_DOWN. Reaches level 0 with target 0 -> OFF. Target 1 -> RAMP_UP.
- FSM transitions on target changes happen in the cycle after `led_in_q` changes, independent of `step_tick`.
- A reversal mid-ramp continues from the current level. The level never jumps.
- Lit condition, registered: lit = (level == 255) | (`pwm_cnt` < level).
  - Level 0 gives constant off; level 255 gives constant on (no 1/256 glitch).
  - Otherwise the LED is lit for exactly `level` cycles out of every 256.
- `led_out` = lit XOR ACTIVE_LOW, registered, so pin latency is 1 cycle after the compare.
- `at_target` = (state == ON) | (state == OFF). It is a registered output.
- Latency from a `led_in` edge to the first level change: 1 cycle (`led_in_q`), then the next `step_tick`, then the level register updates.
- Simultaneous `step_tick` and target reversal: the step uses the new `led_in_q` value, i.e. the direction is the registered target in that cycle.
- A target toggled and restored between ticks causes no level change. The FSM may briefly show RAMP_* and `at_target` may drop for those cycles.
- Channels are fully independent and share only the prescaler and `pwm_cnt`.

Test Plan:
- Bench parameters throughout: STEP_DIV=4, STEP_SIZE=16, ACTIVE_LOW=1.
- Reset: hold reset_n=0 for 3 clks with `led_in`=2'b11 -> `led_out`=2'b11, `at_target`=2'b11, levels 0. Release -> ramp begins within 5 clks.
- Ramp up: `led_in`=2'b01 from OFF -> ch0 level 16, 32, ... saturates at 255 on the 16th tick (64 clks ±4). `at_target[0]` falls, then rises at 255. `led_out[0]` is constantly 0 once the level is 255. Ch1 stays at 1.
- Duty: freeze ch0 at level 64 (target toggled off at level 64) -> over 256 clks `led_out[0]`=0 for exactly 64 clks. Then re-verify level 0 gives 256 clks of 1.
- Reversal: at level 128 in RAMP_UP, set `led_in[0]`=0 -> next tick level 112. Reaches 0 after 8 ticks in OFF. There is no jump to 0 or 255.
- Saturation with STEP_SIZE=200: ramp gives 0->200->255 and 255->55->0. No wrap.
- Reset mid-ramp: assert reset_n=0 with ch1 at level 96 -> next edge level 0 and `led_out[1]`=1. After release with `led_in[1]`=1 the ramp restarts from 0.
